// File: rtl/imem_loader.sv
// Instruction-memory loader: accepts 32-bit words over a valid/ready
// handshake and writes them byte-by-byte, little-endian, into a byte memory.
module imem_loader #(
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          word_valid,
  input  logic [31:0]   word_data,
  input  logic          word_last,
  output logic          word_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          wrapped,
  output logic [5:0]    words_written
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] laddr_q, laddr_d;
  logic [31:0]   data_q, data_d;
  logic          last_q, last_d;
  logic [1:0]    idx_q, idx_d;
  logic          wrap_q, wrap_d;
  logic [5:0]    cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      laddr_q <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      idx_q   <= 2'd0;
      wrap_q  <= 1'b0;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      laddr_q <= laddr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    laddr_d    = laddr_q;
    data_d     = data_q;
    last_d     = last_q;
    idx_d      = idx_q;
    wrap_d     = wrap_q;
    cnt_d      = cnt_q;
    word_ready = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = laddr_q;
    mem_wdata  = 8'd0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        done = (state_q == S_DONE);
        if (start) begin
          state_d = S_ACCEPT;
          addr_d  = base_addr;
          wrap_d  = 1'b0;
          cnt_d   = 6'd0;
        end
      end
      S_ACCEPT: begin
        busy       = 1'b1;
        word_ready = 1'b1;
        if (word_valid) begin
          data_d  = word_data;
          last_d  = word_last;
          idx_d   = 2'd0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = data_q[8*idx_q +: 8];
        laddr_d   = addr_q;
        addr_d    = addr_q + AW'(1);
        idx_d     = idx_q + 2'd1;
        if (addr_q == AW'(DEPTH - 1)) wrap_d = 1'b1;
        // Word only counts once its final byte has gone out.
        if (idx_q == 2'd3) begin
          if (cnt_q != 6'd32) cnt_d = cnt_q + 6'd1;
          state_d = last_q ? S_DONE : S_ACCEPT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign wrapped       = wrap_q;
  assign words_written = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a scoreboard of expected byte writes.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [6:0] base_addr;
  logic       word_valid;
  logic [31:0] word_data;
  logic       word_last;
  logic       word_ready;
  logic       mem_we;
  logic [6:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       busy;
  logic       done;
  logic       wrapped;
  logic [5:0] words_written;

  typedef struct packed {
    logic [6:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        exp_q[$];
  int         n_assert = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         nwr      = 0;
  int         first_cyc = 0;
  int         last_cyc  = 0;
  logic [6:0] exp_addr;
  logic       exp_wrap;

  imem_loader #(.DEPTH(128), .AW(7)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .base_addr     (base_addr),
    .word_valid    (word_valid),
    .word_data     (word_data),
    .word_last     (word_last),
    .word_ready    (word_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .busy          (busy),
    .done          (done),
    .wrapped       (wrapped),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (nwr == 0) first_cyc = cyc;
      last_cyc = cyc;
      nwr++;
      n_assert++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL wr_unexpected: observed addr %0h data %0h expected none",
               mem_addr, mem_wdata);
      end
      if (exp_q.size() > 0) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {25'd0, mem_addr}, {25'd0, e.a});
        chk("wr_data", {24'd0, mem_wdata}, {24'd0, e.d});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [6:0] a);
    start     = 1'b1;
    base_addr = a;
    step();
    start     = 1'b0;
    exp_addr  = a;
    exp_wrap  = 1'b0;
  endtask

  // Offers one word; pushes the first nb bytes it is expected to write.
  task automatic send_word(input logic [31:0] d, input logic l,
                           input int nb);
    int i;
    word_valid = 1'b1;
    word_data  = d;
    word_last  = l;
    i = 0;
    while (word_ready !== 1'b1 && i < 20) begin
      step();
      i++;
    end
    chk("ready_timeout", {31'd0, word_ready}, 32'd1);
    for (int k = 0; k < nb; k++) begin
      wr_t e;
      e.a = exp_addr;
      e.d = d[8*k +: 8];
      exp_q.push_back(e);
      if (exp_addr == 7'd127) exp_wrap = 1'b1;
      exp_addr = exp_addr + 7'd1;
    end
    step();
    word_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && done !== 1'b1; i++) step();
    chk("done_timeout", {31'd0, done}, 32'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    word_valid = 1'b0;
    word_data  = '0;
    word_last  = 1'b0;
    exp_addr   = '0;
    exp_wrap   = 1'b0;
    #1;
    chk("rst_ready", {31'd0, word_ready}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", {25'd0, mem_addr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ww", {26'd0, words_written}, 32'd0);
    #20 rst_n = 1'b1;
    step();

    // single word at 4
    do_start(7'd4);
    chk("busy_accept", {31'd0, busy}, 32'd1);
    send_word(32'h34020026, 1'b1, 4);
    wait_done();
    chk("c1_ww", {26'd0, words_written}, 32'd1);
    chk("c1_wrap", {31'd0, wrapped}, 32'd0);
    chk("c1_busy", {31'd0, busy}, 32'd0);
    chk("c1_we", {31'd0, mem_we}, 32'd0);
    chk("c1_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("c1_addr", {25'd0, mem_addr}, 32'd7);

    // seven back-to-back words
    do_start(7'd0);
    chk("c2_done_clr", {31'd0, done}, 32'd0);
    nwr = 0;
    for (int w = 0; w < 7; w++)
      send_word(32'hA0B0C000 + 32'(w * 17), (w == 6), 4);
    wait_done();
    chk("c2_nwr", nwr, 32'd28);
    chk("c2_span", last_cyc - first_cyc, 32'd33);
    chk("c2_ww", {26'd0, words_written}, 32'd7);
    chk("c2_addr", {25'd0, mem_addr}, 32'd27);

    // wrap from 127 to 0
    do_start(7'd124);
    send_word(32'h08000003, 1'b0, 4);
    send_word(32'hAE020001, 1'b1, 4);
    wait_done();
    chk("c3_wrap", {31'd0, wrapped}, {31'd0, exp_wrap});
    chk("c3_addr", {25'd0, mem_addr}, 32'd3);
    chk("c3_ww", {26'd0, words_written}, 32'd2);

    // valid held low in ACCEPT
    do_start(7'd40);
    for (int i = 0; i < 10; i++) begin
      chk("c4_ready", {31'd0, word_ready}, 32'd1);
      chk("c4_we", {31'd0, mem_we}, 32'd0);
      step();
    end
    send_word(32'hDEADBEEF, 1'b1, 4);
    wait_done();
    chk("c4_ww", {26'd0, words_written}, 32'd1);

    // reset after the second byte
    do_start(7'd0);
    send_word(32'h11223344, 1'b1, 2);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("c5_we", {31'd0, mem_we}, 32'd0);
    chk("c5_addr", {25'd0, mem_addr}, 32'd0);
    chk("c5_busy", {31'd0, busy}, 32'd0);
    chk("c5_ww", {26'd0, words_written}, 32'd0);
    chk("c5_ready", {31'd0, word_ready}, 32'd0);
    #12 rst_n = 1'b1;
    step();
    do_start(7'd0);
    send_word(32'h55667788, 1'b1, 4);
    wait_done();
    chk("c5_ww2", {26'd0, words_written}, 32'd1);

    // start during WRITE is ignored
    do_start(7'd8);
    send_word(32'h0BADF00D, 1'b0, 4);
    start     = 1'b1;
    base_addr = 7'd60;
    step();
    step();
    start     = 1'b0;
    send_word(32'hCAFE1234, 1'b1, 4);
    wait_done();
    chk("c6_ww", {26'd0, words_written}, 32'd2);
    chk("c6_addr", {25'd0, mem_addr}, 32'd15);
    chk("c6_wrap", {31'd0, wrapped}, 32'd0);

    step();
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
